program_region_decoder: RTL and testbench
=========================================

PROGRAM_REGION_DECODER -- requirements
Module: program_region_decoder

Interface
REQ-001 Parameter N, default 32, SHALL set the address width in bits.
REQ-002 Parameter NUM_CS, default 4, legal 2..8, SHALL set the number of flash chip selects and protected regions.
REQ-003 Parameter REGION_SIZE, default 32'h0800_0000, power of two, SHALL set the bytes decoded per chip select.
REQ-004 Parameter WAIT_CYCLES, default 2, legal 0..15, SHALL set extra cycles CS is held beyond one.
REQ-005 One clock, clk; reset is RESET, synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 RESET  input  1  synchronous active-high reset.
REQ-008 req  input  1  access request, sampled only in IDLE.
REQ-009 we  input  1  1 = write access, 0 = read, sampled with req.
REQ-010 address  input  N  byte address, sampled with req.
REQ-011 wp_load  input  1  load write-protect mask from wp_data.
REQ-012 wp_data  input  NUM_CS  new mask, bit i protects region i.
REQ-013 CS  output  NUM_CS  registered one-hot active-high chip selects.
REQ-014 WP  output  1  registered write-protect to flash, valid while any CS bit is high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  one-cycle pulse on rejected access.

Function
REQ-018 Region index SHALL be address[N-1:log2(REGION_SIZE)]; region i spans [i*REGION_SIZE, (i+1)*REGION_SIZE-1].
REQ-019 FSM states SHALL be IDLE, ACCESS, DONE, ERROR.
REQ-020 IDLE with req=1 SHALL latch address, we and the current mask bit of the region; next state ERROR if region >= NUM_CS or (we=1 and mask bit=1), else ACCESS.
REQ-021 ACCESS SHALL drive CS[region]=1 and WP=latched mask bit for exactly WAIT_CYCLES+1 cycles, then go to DONE.
REQ-022 DONE SHALL assert done=1 with CS=0, WP=0 for one cycle, then return to IDLE.
REQ-023 ERROR SHALL assert err=1 with CS=0, WP=0 for one cycle, then return to IDLE; no CS bit is ever asserted for a rejected access.
REQ-024 Latency: req sampled at edge 0 -> CS high after edges 1..WAIT_CYCLES+1, done high after edge WAIT_CYCLES+2; err high after edge 1.
REQ-025 req while busy=1 SHALL be ignored and not queued; req must be re-presented in IDLE.
REQ-026 wp_load SHALL update the mask at the next edge in any state; an in-flight access keeps its latched WP value.
REQ-027 wp_load and req in the same IDLE cycle: protection check SHALL use the old mask.
REQ-028 Reads SHALL never be rejected by the mask; a read of a protected region drives WP=1.
REQ-029 Addresses above NUM_CS*REGION_SIZE-1, including any upper bits set, SHALL take the ERROR path.
REQ-030 At most one CS bit SHALL be high in any cycle; done and err SHALL never both be high.

Reset
REQ-031 RESET=1 at an edge SHALL force IDLE, CS=0, WP=0, busy=0, done=0, err=0, mask=all ones, from any state including mid-ACCESS.
REQ-032 RESET SHALL take priority over req and wp_load in the same cycle.

Structure
REQ-033 Package program_region_pkg SHALL hold the FSM state typedef and the default N, NUM_CS, REGION_SIZE, WAIT_CYCLES constants.
REQ-034 The hold-time counter SHALL be one sub-module, access_wait_counter (load, decrement, zero flag, synchronous RESET).

Verification (defaults, mask after reset = 4'b1111)
REQ-035 Read 32'h0000_0BCD -> CS=4'b0001 for 3 cycles, WP=1, done pulse on the 4th cycle, err=0.
REQ-036 wp_load with wp_data=4'b0000, then write 32'h0800_0CBA -> CS=4'b0010 for 3 cycles, WP=0, done pulse.
REQ-037 wp_load with wp_data=4'b0010, then write 32'h0800_0CBA -> err pulse 1 cycle after req, CS stays 0.
REQ-038 Read 32'h2000_0DEF -> err pulse, CS stays 0; reads of 32'h07FF_FFFF and 32'h0800_0000 -> CS0 and CS1 respectively.
REQ-039 Second req during ACCESS is ignored (exactly one done). RESET mid-ACCESS -> all outputs 0 on the next edge and mask 4'b1111.

Source files
------------

// File: rtl/program_region_decoder_pkg.sv
// Shared types and default parameters for the program region decoder.
package program_region_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned      DEF_N           = 32;
  localparam int unsigned      DEF_NUM_CS      = 4;
  localparam longint unsigned  DEF_REGION_SIZE = 64'h0000_0000_0800_0000;
  localparam int unsigned      DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/program_region_decoder_if.sv
// Request / chip-select bundle between a bus master and the region decoder.
interface program_region_decoder_if
  import program_region_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned NUM_CS = DEF_NUM_CS
);

  logic              req;
  logic              we;
  logic [N-1:0]      address;
  logic              wp_load;
  logic [NUM_CS-1:0] wp_data;
  logic [NUM_CS-1:0] CS;
  logic              WP;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, we, address, wp_load, wp_data,
    input  CS, WP, busy, done, err
  );

  modport slave (
    input  req, we, address, wp_load, wp_data,
    output CS, WP, busy, done, err
  );

endinterface

// File: rtl/program_region_decoder_wait.sv
// Down-counter that times how long a chip select is held.
module access_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/program_region_decoder.sv
// Decodes a byte address into one of NUM_CS flash chip selects, enforcing a
// per-region write-protect mask and holding CS for WAIT_CYCLES+1 cycles.
module program_region_decoder
  import program_region_pkg::*;
#(
  parameter int unsigned     N           = DEF_N,
  parameter int unsigned     NUM_CS      = DEF_NUM_CS,
  parameter longint unsigned REGION_SIZE = DEF_REGION_SIZE,
  parameter int unsigned     WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                     clk,
  input  logic                     RESET,
  program_region_decoder_if.slave  bus
);

  localparam int unsigned RB = $clog2(REGION_SIZE);
  localparam int unsigned RW = N - RB;

  state_t            r_state;
  logic [NUM_CS-1:0] r_mask;
  logic [NUM_CS-1:0] r_cs;
  logic              r_wp;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [RW-1:0]     w_region;
  logic              w_in_range;
  logic              w_mask_bit;
  logic [NUM_CS-1:0] w_onehot;
  logic              w_reject;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic [3:0]        w_count;
  logic              w_unused;

  // Offset bits inside a region play no part in decoding.
  assign w_unused = ^{bus.address[RB-1:0], w_count};

  assign w_region   = bus.address[N-1:RB];
  assign w_in_range = (w_region < RW'(NUM_CS));

  // Region decode: one-hot select and the mask bit for the addressed region.
  always_comb begin
    w_mask_bit = 1'b0;
    w_onehot   = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (w_region == RW'(i)) begin
        w_mask_bit  = r_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_reject = !w_in_range || (bus.we && w_mask_bit);
  assign w_load   = (r_state == ST_IDLE) && bus.req && !w_reject;
  assign w_dec    = (r_state == ST_ACCESS) && !w_zero;

  access_wait_counter #(
    .W (4)
  ) u_wait (
    .clk        (clk),
    .RESET      (RESET),
    .i_load     (w_load),
    .i_load_val (4'(WAIT_CYCLES)),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // Write-protect mask; the FSM samples the pre-update value in the same cycle.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_mask <= '1;
    end else if (bus.wp_load) begin
      r_mask <= bus.wp_data;
    end
  end

  // Access FSM with registered CS/WP/busy/done/err.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cs    <= '0;
      r_wp    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (bus.req) begin
            r_busy <= 1'b1;
            if (w_reject) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_ACCESS;
              r_cs    <= w_onehot;
              r_wp    <= w_mask_bit;
            end
          end
        end
        ST_ACCESS: begin
          if (w_zero) begin
            r_state <= ST_DONE;
            r_cs    <= '0;
            r_wp    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        ST_ERROR: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs    <= '0;
          r_wp    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CS   = r_cs;
  assign bus.WP   = r_wp;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_program_region_decoder.sv
// Directed-vector bench for program_region_decoder at default parameters.
module tb_program_region_decoder;
  import program_region_pkg::*;

  localparam int unsigned WAITC = 2;

  logic clk;
  logic RESET;
  int unsigned n_checks;
  int unsigned n_fail;

  program_region_decoder_if #(.N(32), .NUM_CS(4)) bus ();

  program_region_decoder #(
    .N           (32),
    .NUM_CS      (4),
    .REGION_SIZE (64'h0800_0000),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mask(input logic [3:0] m);
    bus.wp_load = 1'b1;
    bus.wp_data = m;
    step();
    bus.wp_load = 1'b0;
  endtask

  // Present one request and check the whole response against expectations.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic wr,
                           input logic exp_ok, input logic [3:0] exp_cs, input logic exp_wp);
    bus.req     = 1'b1;
    bus.address = addr;
    bus.we      = wr;
    step();
    bus.req = 1'b0;
    if (exp_ok) begin
      for (int unsigned c = 0; c < WAITC + 1; c++) begin
        if (c != 0) step();
        check({tag, "_cs"},   32'(bus.CS),   32'(exp_cs));
        check({tag, "_wp"},   32'(bus.WP),   32'(exp_wp));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_derr"}, {30'd0, bus.done, bus.err}, 32'd0);
      end
      step();
      check({tag, "_done"},   {30'd0, bus.done, bus.err}, 32'd2);
      check({tag, "_cs_off"}, {27'd0, bus.CS, bus.WP}, 32'd0);
      step();
      check({tag, "_idle"}, {28'd0, bus.busy, bus.done, bus.err, bus.WP}, 32'd0);
    end else begin
      check({tag, "_err"},   {30'd0, bus.done, bus.err}, 32'd1);
      check({tag, "_cs_off"}, {27'd0, bus.CS, bus.WP}, 32'd0);
      check({tag, "_busy"},  32'(bus.busy), 32'd1);
      step();
      check({tag, "_idle"}, {23'd0, bus.busy, bus.done, bus.err, bus.CS, bus.WP}, 32'd0);
    end
  endtask

  initial begin
    int unsigned n_done;
    int unsigned n_err;
    n_checks    = 0;
    n_fail      = 0;
    RESET       = 1'b1;
    bus.req     = 1'b0;
    bus.we      = 1'b0;
    bus.address = '0;
    bus.wp_load = 1'b0;
    bus.wp_data = '0;
    step();
    step();
    RESET = 1'b0;
    check("reset_outs", {23'd0, bus.busy, bus.done, bus.err, bus.CS, bus.WP}, 32'd0);

    do_access("rd_r0",     32'h0000_0BCD, 1'b0, 1'b1, 4'b0001, 1'b1);
    load_mask(4'b0000);
    do_access("wr_r1",     32'h0800_0CBA, 1'b1, 1'b1, 4'b0010, 1'b0);
    load_mask(4'b0010);
    do_access("wr_r1_prot", 32'h0800_0CBA, 1'b1, 1'b0, 4'b0000, 1'b0);
    do_access("rd_r4",     32'h2000_0DEF, 1'b0, 1'b0, 4'b0000, 1'b0);
    do_access("rd_r0_top", 32'h07FF_FFFF, 1'b0, 1'b1, 4'b0001, 1'b0);
    do_access("rd_r1_bot", 32'h0800_0000, 1'b0, 1'b1, 4'b0010, 1'b1);
    do_access("rd_upper",  32'hF000_0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    do_access("wr_r3",     32'h1800_0000, 1'b1, 1'b1, 4'b1000, 1'b0);

    // wp_load together with req: old mask (0010) still protects region 1.
    bus.wp_load = 1'b1;
    bus.wp_data = 4'b0000;
    do_access("wr_oldmask", 32'h0800_0004, 1'b1, 1'b0, 4'b0000, 1'b0);
    bus.wp_load = 1'b0;
    do_access("wr_newmask", 32'h0800_0004, 1'b1, 1'b1, 4'b0010, 1'b0);

    // Mask change during ACCESS leaves the latched WP alone.
    bus.req     = 1'b1;
    bus.we      = 1'b0;
    bus.address = 32'h1000_0000;
    step();
    bus.req     = 1'b0;
    bus.wp_load = 1'b1;
    bus.wp_data = 4'b1111;
    check("inflt_cs0", 32'(bus.CS), 32'h4);
    check("inflt_wp0", 32'(bus.WP), 32'h0);
    step();
    bus.wp_load = 1'b0;
    check("inflt_wp1", 32'(bus.WP), 32'h0);
    step();
    check("inflt_wp2", {27'd0, bus.CS, bus.WP}, 32'h8);
    step();
    check("inflt_done", 32'(bus.done), 32'h1);
    step();
    do_access("rd_r2_prot", 32'h1000_0000, 1'b0, 1'b1, 4'b0100, 1'b1);

    // Second req during ACCESS must not start another access.
    n_done = 0;
    n_err  = 0;
    bus.req     = 1'b1;
    bus.we      = 1'b0;
    bus.address = 32'h0000_0010;
    for (int unsigned c = 0; c < 8; c++) begin
      if (c == 3) bus.req = 1'b0;
      step();
      if (bus.done) n_done++;
      if (bus.err)  n_err++;
      if ($countones(bus.CS) > 1) n_err++;
    end
    check("dup_done_cnt", n_done, 32'd1);
    check("dup_err_cnt",  n_err,  32'd0);
    check("dup_busy",     32'(bus.busy), 32'd0);

    // Reset in ACCESS, colliding with req and wp_load.
    load_mask(4'b0000);
    bus.req     = 1'b1;
    bus.we      = 1'b1;
    bus.address = 32'h0000_0000;
    step();
    bus.req = 1'b0;
    step();
    check("rst_pre_cs", 32'(bus.CS), 32'h1);
    RESET       = 1'b1;
    bus.req     = 1'b1;
    bus.wp_load = 1'b1;
    bus.wp_data = 4'b0000;
    step();
    check("rst_mid_outs", {23'd0, bus.busy, bus.done, bus.err, bus.CS, bus.WP}, 32'd0);
    RESET       = 1'b0;
    bus.req     = 1'b0;
    bus.wp_load = 1'b0;
    do_access("rst_mask_all1", 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
